// File: rtl/sram_decode_mux.sv
// Address decode (6:64 rows, 4:16 column groups) and 64:4 read mux for the 1024x4 SRAM macro.
// Optional address register enabled by defining SRAM_ADDR_LATCH_EN; otherwise decoders follow addr directly.
module sram_decode_mux #(
  parameter int ROW_BITS  = 6,
  parameter int COL_BITS  = 4,
  parameter int WORD_SIZE = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ROW_BITS+COL_BITS-1:0]      addr,
  input  logic                              addr_latch,
  input  logic                              row_enable,
  input  logic                              col_enable,
  input  logic                              read_enable,
  input  logic [(2**COL_BITS)*WORD_SIZE-1:0] col_data,
  output logic [(2**ROW_BITS)-1:0]          row_select,
  output logic [(2**COL_BITS)-1:0]          col_select,
  output logic [WORD_SIZE-1:0]              data_out
);

  localparam int NUM_ROWS  = 2**ROW_BITS;
  localparam int NUM_WORDS = 2**COL_BITS;
  localparam int ADDR_BITS = ROW_BITS + COL_BITS;

  logic [ADDR_BITS-1:0] addr_eff_s;
  logic [ROW_BITS-1:0]  row_addr_s;
  logic [COL_BITS-1:0]  col_addr_s;
  logic [WORD_SIZE-1:0] mux_word_s;

`ifdef SRAM_ADDR_LATCH_EN
  logic [ADDR_BITS-1:0] addr_r;

  // Address register: loads on addr_latch, holds otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_r <= {ADDR_BITS{1'b0}};
    end else if (addr_latch) begin
      addr_r <= addr;
    end else begin
      addr_r <= addr_r;
    end
  end

  assign addr_eff_s = addr_r;
`else
  // Without the register the latch strobe has no function
  logic unused_latch_s;
  assign unused_latch_s = addr_latch;
  assign addr_eff_s     = addr;
`endif

  assign row_addr_s = addr_eff_s[ADDR_BITS-1:COL_BITS];
  assign col_addr_s = addr_eff_s[COL_BITS-1:0];

  // One-hot decoders, all-zero when their enable is low
  always_comb begin
    row_select = {NUM_ROWS{1'b0}};
    col_select = {NUM_WORDS{1'b0}};
    if (row_enable) begin
      row_select = {{(NUM_ROWS-1){1'b0}}, 1'b1} << row_addr_s;
    end else begin
      row_select = {NUM_ROWS{1'b0}};
    end
    if (col_enable) begin
      col_select = {{(NUM_WORDS-1){1'b0}}, 1'b1} << col_addr_s;
    end else begin
      col_select = {NUM_WORDS{1'b0}};
    end
  end

  // AND-OR fold of the bitlines down to the selected word (word j on bitlines 4j..4j+3)
  always_comb begin
    mux_word_s = {WORD_SIZE{1'b0}};
    for (int j = 0; j < NUM_WORDS; j++) begin
      mux_word_s = mux_word_s |
                   ({WORD_SIZE{col_select[j]}} & col_data[j*WORD_SIZE +: WORD_SIZE]);
    end
  end

  // Read capture register; zero whenever read_enable is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= {WORD_SIZE{1'b0}};
    end else if (read_enable) begin
      data_out <= mux_word_s;
    end else begin
      data_out <= {WORD_SIZE{1'b0}};
    end
  end

endmodule

// File: tb/tb_sram_decode_mux.sv
// Directed self-checking bench for sram_decode_mux; expectations adapt to SRAM_ADDR_LATCH_EN.
module tb_sram_decode_mux;

  logic        clk;
  logic        rst_n;
  logic [9:0]  addr;
  logic        addr_latch;
  logic        row_enable;
  logic        col_enable;
  logic        read_enable;
  logic [63:0] col_data;
  logic [63:0] row_select;
  logic [15:0] col_select;
  logic [3:0]  data_out;

  int tests_run;
  int tests_failed;

  sram_decode_mux dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr        (addr),
    .addr_latch  (addr_latch),
    .row_enable  (row_enable),
    .col_enable  (col_enable),
    .read_enable (read_enable),
    .col_data    (col_data),
    .row_select  (row_select),
    .col_select  (col_select),
    .data_out    (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] exp64;
    tests_run    = 0;
    tests_failed = 0;
    rst_n       = 1'b0;
    addr        = 10'h000;
    addr_latch  = 1'b0;
    row_enable  = 1'b0;
    col_enable  = 1'b0;
    read_enable = 1'b0;
    col_data    = 64'h0;

    // Reset with enables low
    tick();
    tick();
    check("reset_row", row_select, 64'h0);
    check("reset_col", {48'h0, col_select}, 64'h0);
    check("reset_data", {60'h0, data_out}, 64'h0);
    rst_n = 1'b1;

    // Row sweep
    row_enable = 1'b1;
    for (int r = 0; r < 64; r++) begin
      addr       = 10'(r << 4);
      addr_latch = 1'b1;
      tick();
      addr_latch = 1'b0;
      exp64 = 64'h1 << r;
      check("row_sweep", row_select, exp64);
      check("row_onehot", 64'($countones(row_select)), 64'd1);
    end
    row_enable = 1'b0;
    #1;
    check("row_disabled", row_select, 64'h0);

    // Column sweep
    col_enable = 1'b1;
    for (int j = 0; j < 16; j++) begin
      addr       = 10'(j);
      addr_latch = 1'b1;
      tick();
      addr_latch = 1'b0;
      exp64 = 64'h1 << j;
      check("col_sweep", {48'h0, col_select}, exp64);
    end
    col_enable = 1'b0;
    #1;
    check("col_disabled", {48'h0, col_select}, 64'h0);
    check("row_still_off", row_select, 64'h0);

    // Read mux
    col_data   = 64'hFEDCBA9876543210;
    col_enable = 1'b1;
    addr       = 10'h005;
    addr_latch = 1'b1;
    tick();
    addr_latch  = 1'b0;
    read_enable = 1'b1;
    tick();
    check("read_word5", {60'h0, data_out}, 64'h5);
    read_enable = 1'b0;
    addr        = 10'h00F;
    addr_latch  = 1'b1;
    tick();
    addr_latch  = 1'b0;
    read_enable = 1'b1;
    tick();
    check("read_wordF", {60'h0, data_out}, 64'hF);

    // Gating
    read_enable = 1'b0;
    addr        = 10'h3A7;
    addr_latch  = 1'b1;
    tick();
    addr_latch = 1'b0;
    tick();
    check("gate_read_off", {60'h0, data_out}, 64'h0);
    read_enable = 1'b1;
    col_enable  = 1'b0;
    tick();
    check("gate_col_off", {60'h0, data_out}, 64'h0);
    col_enable = 1'b1;
    tick();
    check("gate_reenable", {60'h0, data_out}, 64'h7);
    tick();
    check("hold_while_read", {60'h0, data_out}, 64'h7);
    read_enable = 1'b0;
    tick();
    check("zero_after_read_off", {60'h0, data_out}, 64'h0);

    // Simultaneous latch and read
    addr       = 10'h001;
    addr_latch = 1'b1;
    tick();
    addr        = 10'h002;
    addr_latch  = 1'b1;
    read_enable = 1'b1;
    tick();
    addr_latch = 1'b0;
`ifdef SRAM_ADDR_LATCH_EN
    check("simul_old_addr", {60'h0, data_out}, 64'h1);
`else
    check("simul_direct_addr", {60'h0, data_out}, 64'h2);
`endif
    tick();
    check("simul_new_addr", {60'h0, data_out}, 64'h2);

    // Reset mid-read with enables high
    row_enable = 1'b1;
    rst_n      = 1'b0;
    tick();
    check("reset_mid_read", {60'h0, data_out}, 64'h0);
`ifdef SRAM_ADDR_LATCH_EN
    check("reset_col_idx0", {48'h0, col_select}, 64'h1);
    check("reset_row_idx0", row_select, 64'h1);
`else
    check("reset_col_direct", {48'h0, col_select}, 64'h4);
    check("reset_row_direct", row_select, 64'h1);
`endif
    rst_n = 1'b1;

    // Address change without latch strobe
    addr = 10'h3FF;
    #1;
`ifdef SRAM_ADDR_LATCH_EN
    check("no_latch_hold_row", row_select, 64'h1);
    check("no_latch_hold_col", {48'h0, col_select}, 64'h1);
`else
    check("direct_follow_row", row_select, 64'h8000000000000000);
    check("direct_follow_col", {48'h0, col_select}, 64'h8000);
`endif
    tick();
    check("read_after_addr_change",
          {60'h0, data_out},
`ifdef SRAM_ADDR_LATCH_EN
          64'h0
`else
          64'hF
`endif
    );

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
